// File: rtl/uart_tx_scheduler.sv
// Game-state broadcast scheduler: snapshots the fields on frame_tick and streams six
// tagged 16-bit words (12 bytes, high byte first) over a valid/ready byte interface.
module uart_tx_scheduler #(
  parameter int          BYTE_GAP     = 0,
  parameter logic [11:0] SYNC_PAYLOAD = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [11:0] pl1_posx,
  input  logic [11:0] pl1_posy,
  input  logic [11:0] ball_posx,
  input  logic [11:0] ball_posy,
  input  logic [3:0]  pl1_score,
  input  logic [3:0]  pl2_score,
  input  logic        flag_point,
  input  logic        end_game,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [7:0]  overrun_cnt
);

  typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO, GAP} state_t;

  typedef struct packed {
    logic [11:0] pl1_posx;
    logic [11:0] pl1_posy;
    logic [11:0] ball_posx;
    logic [11:0] ball_posy;
    logic [11:0] status;
  } snap_t;

  localparam bit         HAS_GAP  = (BYTE_GAP > 0);
  localparam logic [7:0] GAP_LOAD = 8'(BYTE_GAP - 1);
  localparam logic [2:0] LAST_IDX = 3'd5;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        next_lo_q, next_lo_d;
  logic        frame_end_q, frame_end_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  snap_t       snap_q, snap_d;
  logic        pending_q, pending_d;
  logic [7:0]  overrun_q, overrun_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;

  snap_t       snap_in;
  logic        busy_tick;
  logic        restart;
  logic        go_next;
  logic        present;

  function automatic logic [15:0] word_of(input snap_t s, input logic [2:0] idx);
    logic [15:0] w;
    case (idx)
      3'd1:    w = {4'h1, s.pl1_posx};
      3'd2:    w = {4'h2, s.pl1_posy};
      3'd3:    w = {4'h3, s.ball_posx};
      3'd4:    w = {4'h4, s.ball_posy};
      3'd5:    w = {4'h5, s.status};
      default: w = {4'hF, SYNC_PAYLOAD};
    endcase
    return w;
  endfunction

  function automatic logic [7:0] byte_of(input snap_t s, input logic [2:0] idx, input logic lo);
    logic [15:0] w;
    w = word_of(s, idx);
    return lo ? w[7:0] : w[15:8];
  endfunction

  assign snap_in = {pl1_posx, pl1_posy, ball_posx, ball_posy,
                    pl1_score, pl2_score, 2'b00, flag_point, end_game};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      next_lo_q   <= 1'b0;
      frame_end_q <= 1'b0;
      gap_cnt_q   <= 8'd0;
      snap_q      <= '0;
      pending_q   <= 1'b0;
      overrun_q   <= 8'd0;
      tx_data_q   <= 8'd0;
      tx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      next_lo_q   <= next_lo_d;
      frame_end_q <= frame_end_d;
      gap_cnt_q   <= gap_cnt_d;
      snap_q      <= snap_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    next_lo_d   = next_lo_q;
    frame_end_d = frame_end_q;
    gap_cnt_d   = gap_cnt_q;
    snap_d      = snap_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    restart     = 1'b0;
    go_next     = 1'b0;
    present     = 1'b0;

    // One tick may be queued behind the running frame; further ones are counted as lost.
    busy_tick = frame_tick && (state_q != IDLE);
    if (busy_tick) begin
      if (pending_q) begin
        if (overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
      end else begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          restart = 1'b1;
          present = 1'b1;
        end
      end
      SEND_HI: begin
        if (tx_ready) begin
          next_lo_d = 1'b1;
          go_next   = 1'b1;
        end
      end
      SEND_LO: begin
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            if (pending_q || frame_tick) begin
              restart = 1'b1;
              go_next = 1'b1;
            end else if (HAS_GAP) begin
              frame_end_d = 1'b1;
              go_next     = 1'b1;
            end else begin
              state_d    = IDLE;
              tx_valid_d = 1'b0;
            end
          end else begin
            idx_d     = idx_q + 3'd1;
            next_lo_d = 1'b0;
            go_next   = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q != 8'd0) begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end else if (frame_end_q) begin
          // Trailing gap finished: a tick seen meanwhile starts the next frame now.
          if (pending_q || frame_tick) begin
            restart = 1'b1;
            present = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          present = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (restart) begin
      snap_d      = snap_in;
      pending_d   = 1'b0;
      idx_d       = 3'd0;
      next_lo_d   = 1'b0;
      frame_end_d = 1'b0;
    end

    if (go_next && HAS_GAP) begin
      state_d    = GAP;
      tx_valid_d = 1'b0;
      gap_cnt_d  = GAP_LOAD;
    end else if (go_next || present) begin
      tx_valid_d = 1'b1;
      tx_data_d  = byte_of(snap_d, idx_d, next_lo_d);
      state_d    = next_lo_d ? SEND_LO : SEND_HI;
    end
  end

  always_comb begin
    tx_data     = tx_data_q;
    tx_valid    = tx_valid_q;
    busy        = (state_q != IDLE);
    overrun_cnt = overrun_q;
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: table vectors, corner-case sequences and a random run
// against a queue-of-bytes reference model (BYTE_GAP=0 instance), plus a BYTE_GAP=3 instance.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, frame_tick, tx_ready, flag_point, end_game;
  logic [11:0] pl1_posx, pl1_posy, ball_posx, ball_posy;
  logic [3:0]  pl1_score, pl2_score;
  logic [7:0]  d0_data, d0_ovr, d3_data, d3_ovr;
  logic        d0_valid, d0_busy, d3_valid, d3_busy;

  uart_tx_scheduler #(.BYTE_GAP(0), .SYNC_PAYLOAD(12'h000)) u_gap0 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .pl1_posx(pl1_posx), .pl1_posy(pl1_posy), .ball_posx(ball_posx), .ball_posy(ball_posy),
    .pl1_score(pl1_score), .pl2_score(pl2_score), .flag_point(flag_point), .end_game(end_game),
    .tx_data(d0_data), .tx_valid(d0_valid), .tx_ready(tx_ready), .busy(d0_busy),
    .overrun_cnt(d0_ovr)
  );

  uart_tx_scheduler #(.BYTE_GAP(3), .SYNC_PAYLOAD(12'h000)) u_gap3 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .pl1_posx(pl1_posx), .pl1_posy(pl1_posy), .ball_posx(ball_posx), .ball_posy(ball_posy),
    .pl1_score(pl1_score), .pl2_score(pl2_score), .flag_point(flag_point), .end_game(end_game),
    .tx_data(d3_data), .tx_valid(d3_valid), .tx_ready(tx_ready), .busy(d3_busy),
    .overrun_cnt(d3_ovr)
  );

  typedef struct {
    logic [11:0] px, py, bx, by;
    logic [3:0]  s1, s2;
    logic        fp, eg;
    logic [95:0] bytes;
  } vec_t;

  vec_t        vt[4];
  int          n_vec = 0;
  int          n_bad = 0;

  // Reference model: bytes still owed for the current frame, plus tick bookkeeping.
  logic [7:0]  mq[$];
  bit          m_pend;
  int          m_ovr;
  logic [7:0]  got[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_k(input logic [95:0] b, input int k);
    return b[95 - 8*k -: 8];
  endfunction

  task automatic push_frame();
    logic [15:0] w[6];
    w[0] = {4'hF, 12'h000};
    w[1] = {4'h1, pl1_posx};
    w[2] = {4'h2, pl1_posy};
    w[3] = {4'h3, ball_posx};
    w[4] = {4'h4, ball_posy};
    w[5] = {4'h5, pl1_score, pl2_score, 2'b00, flag_point, end_game};
    for (int i = 0; i < 6; i++) begin
      mq.push_back(w[i][15:8]);
      mq.push_back(w[i][7:0]);
    end
  endtask

  task automatic load_fields(input vec_t v);
    pl1_posx = v.px; pl1_posy = v.py; ball_posx = v.bx; ball_posy = v.by;
    pl1_score = v.s1; pl2_score = v.s2; flag_point = v.fp; end_game = v.eg;
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare the GAP=0 DUT.
  task automatic step();
    bit acc;
    @(posedge clk);
    acc = (mq.size() != 0) && tx_ready;
    if (mq.size() == 0) begin
      if (frame_tick) push_frame();
    end else begin
      if (frame_tick) begin
        if (m_pend) begin
          if (m_ovr < 255) m_ovr++;
        end else begin
          m_pend = 1'b1;
        end
      end
      if (acc) begin
        void'(mq.pop_front());
        if (mq.size() == 0 && m_pend) begin
          m_pend = 1'b0;
          push_frame();
        end
      end
    end
    #1;
    check("model_ctl", {22'd0, d0_valid, d0_busy, d0_ovr},
          {22'd0, mq.size() != 0, mq.size() != 0, m_ovr[7:0]});
    if (mq.size() != 0) check("model_byte", 32'(d0_data), 32'(mq[0]));
  endtask

  task automatic model_clear();
    mq.delete();
    m_pend = 1'b0;
    m_ovr  = 0;
  endtask

  task automatic do_reset();
    frame_tick = 1'b0;
    tx_ready   = 1'b1;
    rst        = 1'b1;
    model_clear();
    #1;
    check("rst_gap0", {13'd0, d0_valid, d0_busy, d0_ovr, d0_data}, 32'd0);
    check("rst_gap3", {13'd0, d3_valid, d3_busy, d3_ovr, d3_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [95:0] exp2;
    logic [7:0]  prev;
    int          nvalid, nacc, nstall;
    bit          ev;

    vt[0] = '{12'h123, 12'h456, 12'h789, 12'hABC, 4'h3, 4'h5, 1'b1, 1'b0, 96'hF000_1123_2456_3789_4ABC_5352};
    vt[1] = '{12'h000, 12'h000, 12'h000, 12'h000, 4'h0, 4'h0, 1'b0, 1'b0, 96'hF000_1000_2000_3000_4000_5000};
    vt[2] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 4'hF, 4'hF, 1'b1, 1'b1, 96'hF000_1FFF_2FFF_3FFF_4FFF_5FF3};
    vt[3] = '{12'h0AA, 12'h001, 12'h800, 12'h7FF, 4'h9, 4'h0, 1'b0, 1'b1, 96'hF000_10AA_2001_3800_47FF_5901};
    exp2  = 96'hF000_10AA_2456_3789_4ABC_5352;

    rst = 1'b0; frame_tick = 1'b0; tx_ready = 1'b1;
    load_fields(vt[1]);
    #2;
    do_reset();

    // Table: one full frame per record, tx_ready held high.
    for (int v = 0; v < 4; v++) begin
      load_fields(vt[v]);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      for (int k = 0; k < 12; k++) begin
        if (k > 0) step();
        check("tbl_byte", {23'd0, d0_valid, d0_data}, {23'd0, 1'b1, byte_k(vt[v].bytes, k)});
      end
      step();
      check("tbl_idle", {30'd0, d0_valid, d0_busy}, 32'd0);
    end

    // Backpressure: 5-cycle stall on the third byte.
    load_fields(vt[0]);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    got.delete();
    nvalid = 0; nacc = 0; nstall = 0;
    for (int c = 0; c < 60 && d0_busy; c++) begin
      tx_ready = !(nacc == 2 && nstall < 5);
      if (d0_valid) begin
        nvalid++;
        if (tx_ready) begin
          got.push_back(d0_data);
          nacc++;
        end else begin
          nstall++;
          check("bp_hold", 32'(d0_data), 32'h11);
        end
      end
      step();
    end
    tx_ready = 1'b1;
    check("bp_done", 32'(d0_busy), 32'd0);
    check("bp_cycles", 32'(nvalid), 32'd17);
    check("bp_nbytes", 32'(got.size()), 32'd12);
    for (int k = 0; k < got.size() && k < 12; k++)
      check("bp_byte", 32'(got[k]), 32'(byte_k(vt[0].bytes, k)));

    // Second tick mid-frame, with pl1_posx changing under the running frame.
    load_fields(vt[0]);
    frame_tick = 1'b1;
    step();
    check("mid_b0", 32'(d0_data), 32'hF0);
    for (int b = 1; b < 12; b++) begin
      frame_tick = (b == 5);
      if (b == 2) pl1_posx = 12'h0AA;
      step();
      check("mid_f1", {23'd0, d0_valid, d0_data}, {23'd0, 1'b1, byte_k(vt[0].bytes, b)});
    end
    frame_tick = 1'b0;
    for (int b = 0; b < 12; b++) begin
      step();
      check("mid_f2", {23'd0, d0_valid, d0_data}, {23'd0, 1'b1, byte_k(exp2, b)});
    end
    step();
    check("mid_end", {22'd0, d0_valid, d0_busy, d0_ovr}, 32'd0);
    load_fields(vt[0]);

    // Overrun: three extra ticks inside one frame.
    frame_tick = 1'b1;
    step();
    for (int b = 1; b < 12; b++) begin
      frame_tick = (b == 3 || b == 5 || b == 7);
      step();
    end
    frame_tick = 1'b0;
    for (int c = 0; c < 40 && d0_busy; c++) step();
    check("ovr_idle", 32'(d0_busy), 32'd0);
    check("ovr_two", 32'(d0_ovr), 32'd2);

    // Saturation: a tick every cycle for 400 cycles.
    prev = d0_ovr;
    frame_tick = 1'b1;
    for (int c = 0; c < 400; c++) begin
      step();
      check("ovr_mono", 32'(d0_ovr >= prev), 32'd1);
      prev = d0_ovr;
    end
    frame_tick = 1'b0;
    check("ovr_sat", 32'(d0_ovr), 32'hFF);
    for (int c = 0; c < 40 && d0_busy; c++) step();
    check("ovr_sat_idle", {23'd0, d0_busy, d0_ovr}, 32'h0FF);

    // Gap instance: byte every 4th cycle, then a 3-cycle trailing gap.
    do_reset();
    load_fields(vt[0]);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int t = 0; t < 49; t++) begin
      if (t > 0) step();
      ev = (t < 45) && (t % 4 == 0);
      check("gap_ctl", {30'd0, d3_valid, d3_busy}, {30'd0, ev, t < 48});
      if (ev) check("gap_byte", 32'(d3_data), 32'(byte_k(vt[0].bytes, t / 4)));
    end

    // Asynchronous reset mid-frame.
    frame_tick = 1'b1;
    step();
    for (int b = 1; b < 6; b++) begin
      frame_tick = (b == 2 || b == 3 || b == 4);
      step();
    end
    frame_tick = 1'b0;
    check("rstm_pre", 32'(d0_ovr), 32'd2);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    check("rstm_gap0", {21'd0, d0_valid, d0_busy, d0_ovr}, 32'd0);
    check("rstm_gap3", {21'd0, d3_valid, d3_busy, d3_ovr}, 32'd0);
    #1;
    rst = 1'b0;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("rstm_f0", {23'd0, d0_valid, d0_data}, {23'd0, 9'h1F0});
    step();
    check("rstm_00", {23'd0, d0_valid, d0_data}, {23'd0, 9'h100});
    for (int c = 0; c < 40 && d0_busy; c++) step();

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      pl1_posx   = 12'($urandom);
      pl1_posy   = 12'($urandom);
      ball_posx  = 12'($urandom);
      ball_posy  = 12'($urandom);
      pl1_score  = 4'($urandom);
      pl2_score  = 4'($urandom);
      flag_point = 1'($urandom);
      end_game   = 1'($urandom);
      frame_tick = ($urandom_range(0, 24) == 0);
      tx_ready   = ($urandom_range(0, 3) != 0);
      step();
    end
    frame_tick = 1'b0;
    tx_ready   = 1'b1;
    for (int c = 0; c < 40 && d0_busy; c++) step();
    check("rand_drain", 32'(d0_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
